// File: rtl/pisa_pkg.sv
// Shared frame-buffer definitions used by the loader, VGA reader and RAM wrappers.
package pisa_pkg;
    localparam int ADDR_W         = 17;
    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;
endpackage

// File: rtl/byte_packer.sv
// Four-lane little-endian byte assembler; word_out carries the completed word
// combinationally in the same cycle the fourth byte is pushed.
module byte_packer
    import pisa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word_out,
    output logic              word_ready
);
    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0] lane;
    logic [7:0]        lanes [BYTES_PER_WORD-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane <= '0;
            for (int unsigned i = 0; i < BYTES_PER_WORD - 1; i++) begin
                lanes[i] <= '0;
            end
        end else if (clear) begin
            lane <= '0;
        end else if (push) begin
            // The top lane is never stored; it goes straight into word_out.
            for (int unsigned i = 0; i < BYTES_PER_WORD - 1; i++) begin
                if (lane == LANE_W'(i)) begin
                    lanes[i] <= byte_in;
                end
            end
            lane <= lane + LANE_W'(1);
        end
    end

    always_comb begin
        word_out   = {byte_in, lanes[2], lanes[1], lanes[0]};
        word_ready = push && (lane == LANE_W'(BYTES_PER_WORD - 1));
    end
endmodule

// File: rtl/ram_loader.sv
// Streams bytes from a valid/ready source into the frame buffer write port,
// one 32-bit word per four bytes, sequentially from address 0.
module ram_loader #(
    parameter int ADDR_W    = pisa_pkg::ADDR_W,
    parameter int DATA_W    = pisa_pkg::DATA_W,
    parameter int NUM_WORDS = 40000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count
);
    import pisa_pkg::*;

    loader_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic              clear;
    logic              push;
    logic              word_ready;
    logic [DATA_W-1:0] word_out;

    // Abort wins over a byte offered in the same cycle.
    always_comb begin
        push  = byte_valid && byte_ready && !abort;
        clear = ((state == IDLE) && start) || ((state == LOAD) && abort);
    end

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .push       (push),
        .byte_in    (byte_data),
        .word_out   (word_out),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            wren       <= 1'b0;
            wraddress  <= '0;
            data       <= '0;
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            wren <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        addr       <= '0;
                        word_count <= '0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= IDLE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                    end else if (word_ready) begin
                        wren       <= 1'b1;
                        wraddress  <= addr;
                        data       <= word_out;
                        word_count <= word_count + ADDR_W'(1);
                        if (addr == ADDR_W'(NUM_WORDS - 1)) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule
